// File: rtl/hw1_b_ctrl_seq_if.sv
// hw1_b_ctrl_seq_if: valid/ready command channel into the control-word sequencer
interface hw1_b_ctrl_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_ctrl;
    logic [15:0] cmd_data;
    logic [3:0]  cmd_rep;
    modport master (output cmd_valid, cmd_ctrl, cmd_data, cmd_rep, input cmd_ready);
    modport slave (input cmd_valid, cmd_ctrl, cmd_data, cmd_rep, output cmd_ready);
endinterface

// File: rtl/hw1_b_ctrl_seq.sv
// hw1_b_ctrl_seq: FIFO-buffered control/data word sequencer feeding the 4x16 register file
// Define HW1_SEQ_SELCHK_EN to drop commands whose enabled source selects are out of range.
module hw1_b_ctrl_seq #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hw1_b_ctrl_seq_if.slave        cmd,
    input  logic                   flush,
    output logic [15:0]            control,
    output logic [15:0]            data,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] FULL = LW'(DEPTH);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t        state;
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [3:0]    rep_cnt;
    logic [15:0]   h_ctrl, h_data;
    logic [3:0]    h_rep;
    logic          push, pop, bad;
    assign {h_ctrl, h_data, h_rep} = mem[rptr];
    assign cmd.cmd_ready = level != FULL;
    assign push = cmd.cmd_valid && cmd.cmd_ready && !flush;
    assign pop = !flush && level != '0 && (state == IDLE || rep_cnt == '0);
    assign busy = state == ISSUE;
`ifdef HW1_SEQ_SELCHK_EN
    // a select >= 4 has its msb set; only matters where that register is written
    assign bad = |(h_ctrl[3:0] & {h_ctrl[6], h_ctrl[9], h_ctrl[12], h_ctrl[15]});
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err <= 1'b0;
        else err <= pop && bad;
`else
    assign bad = 1'b0;
    assign err = 1'b0;
`endif
    always_ff @(posedge clk)
        if (push) mem[wptr] <= {cmd.cmd_ctrl, cmd.cmd_data, cmd.cmd_rep};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            control <= '0;
            data    <= '0;
            rep_cnt <= '0;
            level   <= '0;
            wptr    <= '0;
            rptr    <= '0;
        end else if (flush) begin
            state   <= IDLE;
            control <= '0;
            rep_cnt <= '0;
            level   <= '0;
            wptr    <= '0;
            rptr    <= '0;
        end else begin
            level <= level + LW'(push) - LW'(pop);
            if (push) wptr <= wptr + AW'(1);
            if (pop) begin
                rptr <= rptr + AW'(1);
                if (bad) begin
                    control <= '0;
                    state   <= IDLE;
                end else begin
                    control <= h_ctrl;
                    data    <= h_data;
                    rep_cnt <= h_rep;
                    state   <= ISSUE;
                end
            end else if (state == IDLE || rep_cnt == '0) begin
                control <= '0;
                state   <= IDLE;
            end else begin
                rep_cnt <= rep_cnt - 4'd1;
            end
        end
    end
endmodule

// File: doc/hw1_b_ctrl_seq.md
# hw1_b_ctrl_seq

Control-word sequencer directly upstream of the 4×16-bit register-file stage. Accepts (control, data, repeat) commands through a valid/ready handshake, buffers them in a small FIFO, and drives the register file's 16-bit control and data inputs one word per clock. A command is held for repeat+1 cycles, so a rotate/shift across R0–R3 is issued as a single command. An idle sequencer drives control = 16'h0000, so all register-file write enables are low and the registers hold.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_ctrl  in  16  control word, register-file format:
  - [15:13], [12:10], [9:7], [6:4]: R0..R3 source selects.
  - [3:0]: write enables, bit0 = R0.
- cmd_data  in  16  data word issued with cmd_ctrl.
- cmd_rep  in  4  extra cycles to hold the word; 0 means issue once.
- flush  in  1  synchronous clear of FIFO and issue engine.
- control  out  16  to register file; registered.
- data  out  16  to register file; registered.
- busy  out  1  issue engine in ISSUE.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- err  out  1  one-cycle pulse on a dropped illegal command; present only with the macro, otherwise tied 0.

## Operation
- **Push:** at the edge where cmd_valid && cmd_ready, {cmd_ctrl, cmd_data, cmd_rep} is written at the tail.
  - While full, cmd_ready = 0 and nothing is written.
- **Pop:** only the issue engine pops, at most one entry per edge.
  - Push and pop on the same edge leave level unchanged.
- **IDLE state:**
  - FIFO non-empty: pop head; load control/data from it; rep_cnt <= head.rep; go to ISSUE.
  - Otherwise: control <= 0; data holds its last value.
- **ISSUE state:**
  - rep_cnt ≠ 0: rep_cnt <= rep_cnt−1; control/data held.
  - rep_cnt = 0 and FIFO non-empty: pop the next entry and load it back-to-back, with no bubble cycle.
  - rep_cnt = 0 and FIFO empty: control <= 0; go to IDLE.
- **flush** (has priority over push and pop):
  - level <= 0 and pointers cleared.
  - control <= 0, rep_cnt <= 0, state <= IDLE.
  - A handshake in the same cycle is discarded.
- **Pointers:** wrap modulo DEPTH. Full and empty are taken from level, not from pointer equality.
- **Reset:** control = 0, data = 0, level = 0, busy = 0, err = 0, state IDLE; cmd_ready = 1 after reset.
- **Reset mid-operation:** FIFO contents are lost, and control reaches 0 asynchronously.

## Timing
- A command accepted at edge k, with FIFO empty and engine idle, appears on control/data after edge k+1 and is held for exactly cmd_rep+1 cycles.
- The register file captures the word on each edge while it is presented. A word held n cycles is therefore applied n times, which is the intended way to rotate n times.
- Back-to-back commands give continuous issue, with no idle cycle between them.
- Edge after the last word, with no next command: control = 0 and busy = 0.
- level is a registered count and updates on the push/pop edge.
- cmd_ready is combinational from level only. There is no combinational path from cmd_valid.

## Configuration
- **HW1_SEQ_SELCHK_EN defined:** illegal commands are checked at pop.
  - A command is illegal if any 3-bit source select ≥ 3'b100 while its write-enable bit is 1.
  - An illegal command is popped and dropped; control <= 0 for that cycle and err pulses high for 1 cycle.
  - The engine then continues normally: the next command is taken at the following edge.
- **Undefined:** no check is made, every word is issued unchanged, and err is constant 0.

## Test plan
- **Reset, then single push:** reset, then push ctrl=16'b011_111_111_111_0001, data=16'h0101, rep=0.
  - control shows that word for exactly 1 cycle, then 16'h0000; R0 = 16'h0101.
- **Back-to-back shift:** push four commands, data 16'h0101..16'h0404, enables 0001/0011/0111/1111.
  - Four consecutive control words with no gap.
  - Final R0..R3 = 0404, 0303, 0202, 0101.
- **Rotation by repeat:** after the shift test, push ctrl=16'b010_000_001_010_1111 with rep=1.
  - Word held for 2 cycles; R0..R3 = 0202, 0101, 0404, 0303.
- **Full FIFO:** hold the engine in a rep=15 command and push DEPTH more commands.
  - cmd_ready = 0 and level = DEPTH; a further cmd_valid is not accepted.
  - All entries are later issued in order.
- **Flush:** flush while busy with 2 entries queued, plus a cmd_valid in the same cycle.
  - Next cycle: control = 0, level = 0, busy = 0; the concurrent command is lost.
- **Select check (macro only):** with HW1_SEQ_SELCHK_EN, push ctrl=16'b111_000_000_000_0001 followed by a legal command.
  - err pulses for 1 cycle with control = 0 during that cycle; the legal word issues at the next edge.
